wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter between the execution units (ALU, MUL, DIV, LSU, …) and the limited register-file/ROB writeback ports. Each cycle it picks up to `wpt` of the `nfu` pending unit results and raises the matching `claim` lines so those units advance their result queues. It drops results younger than an active redirect and registers the granted bundles onto the writeback ports. Selection is round-robin with a starvation override, so a long-latency unit such as the multiplier cannot be locked out by a busy ALU.

## Interface
- `nfu`, 4: number of requesting functional units.
- `wpt`, 2: number of writeback ports; 1 ≤ `wpt` ≤ `nfu`.
- `opsz`, 64: operation-ID space, a power of two; used for redirect age comparison.
- `stv`, 8: starvation threshold in cycles; 2 ≤ `stv` ≤ 15.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high; clock `clk`.
- `redir` in `red_bundle_t`: redirect bundle (`opid`, `topid`).
- `cand` in `exe_bundle_t [nfu]`: head result of each unit. Valid when `opid[15]` is set.
- `claim` out `[nfu]`: combinational; high when the unit's head is taken this cycle.
- `wb` out `exe_bundle_t [wpt]`: registered writeback bundles. A port is valid when its `opid[15]` is set.

## Operation
- **Younger-than-redirect.** Let n = log2(`opsz`). An opid is younger-than-redirect when all of the following hold:
  - `redir.opid[15]` is set;
  - `opid[15]` is set;
  - (opid − topid) mod 2^n ≥ (redir.opid − topid + 1) mod 2^n, using the low n bits of each ID.
- **Eligibility.** Unit i is eligible when `cand[i].opid[15]` is set and the candidate is not younger-than-redirect. Ineligible units are never claimed; each unit squashes its own queue.
- **Starvation counters.** Each unit has a 4-bit counter `sc[i]`, reset to 0.
  - Eligible and not claimed: `sc[i]` increments, saturating at 15.
  - Claimed or ineligible: `sc[i]` clears to 0.
  - Unit i is starved when `sc[i]` ≥ `stv`.
- **Selection order.**
  - Pass 1: starved eligible units, lowest index first.
  - Pass 2: remaining eligible units, scanning from pointer `ptr` upward modulo `nfu`.
  - The first `wpt` units selected are granted. Port k receives the k-th grant, in selection order.
  - Ungranted ports load all-zero.
- **Pointer update.** `ptr` (reset 0) becomes (index of the last pass-2 grant + 1) mod `nfu`. It is unchanged if pass 2 granted nothing.
- **Writeback register.**
  - `wb[k]` loads the granted bundle every cycle; there is no stall.
  - If the bundle being loaded is younger-than-redirect under the current `redir`, its opid is forced to 0 and the other fields are loaded unchanged.
  - A bundle already held in `wb` is not re-checked. The next stage handles redirects for in-flight writebacks.
- **Claim/grant consistency.** `claim[i]` equals granted[i] in the same cycle. At most `wpt` claims are high per cycle.

## Timing
- **Reset.**
  - `wb` = 0, `claim` = 0 (no inputs valid), `ptr` = 0, all `sc` = 0.
  - While `rst` is high, `claim` is forced to 0.
- **Latency.** A candidate offered and claimed in cycle t appears on `wb` in cycle t+1. A unit sees `claim` in the same cycle as its offer and pops on that clock edge.
- **Throughput.** `wpt` results per cycle, sustained.
- **Bounded wait.** An eligible unit waits at most `stv` + `nfu` cycles before it is granted.
- **Simultaneous events.**
  - A redirect in the same cycle as an offer blocks only candidates that are younger-than-redirect; older candidates are still granted.
  - If more than `wpt` units are starved at once, they are granted in lowest-index order. Counters of ungranted starved units keep saturating.
- **Wrap-around.** The `ptr` scan and the opid comparison both wrap modulo their sizes.
- **Reset mid-operation.** All state clears on the next edge, and any offer in that cycle is not claimed.

## Structure
- `exe_bundle_t` and `red_bundle_t` come from `types`.
- Add the younger-than-redirect comparison to `types` as a shared function parameterised by the opid width. Every unit needs the same comparison.
- One natural sub-module: `rr_pick`. It is a combinational rotate-priority selector over an `nfu`-bit eligibility vector, taking the starting pointer and returning up to `wpt` one-hot grants in order. It is instantiated once per pass.
- Counters, `ptr`, and the `wb` register live in `wb_arbiter`.

## Test plan
- **Basic two-port grant.** `nfu`=4, `wpt`=2, reset, then `cand[1]` and `cand[3]` valid (opid 0x8005, 0x8006) → `claim`=4'b1010; next cycle `wb[0].opid`=0x8005 and `wb[1].opid`=0x8006; `ptr`=0.
- **Round-robin rotation.** All 4 units valid continuously → grant pairs {0,1}, {2,3}, {0,1}; `claim` never has more than 2 bits set.
- **Starvation override.** `stv`=3, `ptr` forced so that unit 3 keeps losing while units 0–2 are valid every cycle → unit 3 is claimed no later than 3 + 4 cycles after its first offer.
- **Redirect filtering.** topid=0x8000, `redir.opid`=0x8004, candidates with opid 0x8003 and 0x8007 → only the 0x8003 unit is claimed; `wb[1]`=0 next cycle.
- **Wrap-around.** `opsz`=64, topid=0x803E, `redir.opid`=0x803F, candidate opid 0x8001 → treated as younger and not claimed; candidate opid 0x803E is claimed.
- **Reset mid-stream.** Assert `rst` for one cycle while all units are offering → `claim`=0 that cycle; `wb`=0, `ptr`=0 and all `sc`=0 afterwards; arbitration resumes with grants {0,1}.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
// Shared types and helpers for the writeback arbiter and the execution
// units around it.
//   exe_bundle_t : one unit result (opid[15] is the valid flag)
//   red_bundle_t : redirect bundle (opid of the redirecting op, topid = oldest op)
//   isYounger()  : younger-than-redirect test, parameterised by ID width
package wb_arbiter_pkg;

  localparam int OPID_W = 16;
  localparam int DEST_W = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [OPID_W-1:0] opid;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } exe_bundle_t;

  typedef struct packed {
    logic [OPID_W-1:0] opid;
    logic [OPID_W-1:0] topid;
  } red_bundle_t;

  // Ages are measured from topid in a circular ID space of 2^idBits entries,
  // so the comparison is correct across ID wrap-around. An op is younger when
  // its age is past the redirecting op's age.
  function automatic logic isYounger(input logic [OPID_W-1:0] opid,
                                     input red_bundle_t       redir,
                                     input int                idBits);
    logic [OPID_W-1:0] mask;
    logic [OPID_W-1:0] age;
    logic [OPID_W-1:0] lim;
    mask = OPID_W'((32'd1 << idBits) - 32'd1);
    age  = (opid - redir.topid) & mask;
    lim  = (redir.opid - redir.topid + 16'd1) & mask;
    return redir.opid[OPID_W-1] && opid[OPID_W-1] && (age >= lim);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
// Bus between the execution units and the writeback arbiter.
//   redir : redirect bundle               (units -> arbiter)
//   cand  : head result of each unit      (units -> arbiter)
//   claim : head taken this cycle         (arbiter -> units, combinational)
//   wb    : registered writeback bundles  (arbiter -> register file / ROB)
// Modports: master = unit side, slave = arbiter side.
interface wb_arbiter_if import wb_arbiter_pkg::*; #(
  parameter int NFU = 4,
  parameter int WPT = 2
);

  red_bundle_t                 redir;
  exe_bundle_t [NFU-1:0]       cand;
  logic        [NFU-1:0]       claim;
  exe_bundle_t [WPT-1:0]       wb;

  modport master (output redir, output cand, input claim, input wb);
  modport slave  (input redir, input cand, output claim, output wb);

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// wb_arbiter_rr_pick
// Combinational rotate-priority selector. Scans elig_i starting at start_i
// and wrapping modulo NFU, returning up to WPT one-hot grants in scan order.
//   elig_i  : eligibility vector
//   start_i : index where the scan begins
//   grant_o : grant_o[k] is the one-hot k-th pick (zero if none)
//   valid_o : valid_o[k] set when grant_o[k] holds a pick
module wb_arbiter_rr_pick #(
  parameter int NFU = 4,
  parameter int WPT = 2,
  parameter int PW  = 2
) (
  input  logic [NFU-1:0]          elig_i,
  input  logic [PW-1:0]           start_i,
  output logic [WPT-1:0][NFU-1:0] grant_o,
  output logic [WPT-1:0]          valid_o
);

  logic [2*NFU-1:0] eligShift;
  logic [NFU-1:0]   rotElig;

  // Rotate so that bit 0 is the start position; the scan then uses only
  // constant indices and the picks are rotated back afterwards.
  assign eligShift = {elig_i, elig_i} >> start_i;
  assign rotElig   = eligShift[NFU-1:0];

  always_comb begin
    logic [NFU-1:0]   taken;
    logic [NFU-1:0]   rotGrant;
    logic [2*NFU-1:0] spread;
    taken    = '0;
    rotGrant = '0;
    spread   = '0;
    grant_o  = '0;
    valid_o  = '0;
    for (int k = 0; k < WPT; k++) begin
      rotGrant = '0;
      for (int j = 0; j < NFU; j++) begin
        if (!valid_o[k] && rotElig[j] && !taken[j]) begin
          rotGrant[j] = 1'b1;
          taken[j]    = 1'b1;
          valid_o[k]  = 1'b1;
        end
      end
      spread     = {rotGrant, rotGrant} << start_i;
      grant_o[k] = spread[2*NFU-1:NFU];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Picks up to WPT of NFU pending unit results per cycle, claims them, and
// registers them onto the writeback ports. Starved units (waiting >= STV
// cycles) go first in index order, then round-robin from ptr.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_arbiter_if slave (redir, cand in; claim, wb out)
// Parameters: NFU units, WPT ports, OPSZ opid space (power of two),
// STV starvation threshold (2..15).
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int NFU  = 4,
  parameter int WPT  = 2,
  parameter int OPSZ = 64,
  parameter int STV  = 8
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int PW  = (NFU > 1) ? $clog2(NFU) : 1;
  localparam int IDW = $clog2(OPSZ);

  logic [NFU-1:0]          elig;
  logic [NFU-1:0]          starved;
  logic [NFU-1:0][3:0]     starveCnt_q, starveCnt_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  exe_bundle_t [WPT-1:0]   wb_q, wb_d;

  logic [WPT-1:0][NFU-1:0] p1Grant, p2Grant, slotGrant;
  logic [WPT-1:0]          p1Valid, p2Valid;
  logic [NFU-1:0]          p1Mask, grantMask;

  // Eligibility and starvation status for each unit.
  always_comb begin
    elig    = '0;
    starved = '0;
    for (int i = 0; i < NFU; i++) begin
      elig[i]    = bus.cand[i].opid[OPID_W-1] && !isYounger(bus.cand[i].opid, bus.redir, IDW);
      starved[i] = starveCnt_q[i] >= 4'(STV);
    end
  end

  // Pass 1 scans starved units from index 0 so they go in lowest-index order.
  wb_arbiter_rr_pick #(.NFU(NFU), .WPT(WPT), .PW(PW)) pass1 (
    .elig_i  (elig & starved),
    .start_i ('0),
    .grant_o (p1Grant),
    .valid_o (p1Valid)
  );

  always_comb begin
    p1Mask = '0;
    for (int k = 0; k < WPT; k++) p1Mask |= p1Grant[k];
  end

  wb_arbiter_rr_pick #(.NFU(NFU), .WPT(WPT), .PW(PW)) pass2 (
    .elig_i  (elig & ~p1Mask),
    .start_i (ptr_q),
    .grant_o (p2Grant),
    .valid_o (p2Valid)
  );

  // Pass-1 picks fill the low slots; pass-2 picks follow until WPT slots are
  // used. The pointer moves past the last pass-2 pick that landed in a slot.
  always_comb begin
    int p1Count;
    p1Count   = 0;
    slotGrant = '0;
    ptr_d     = ptr_q;
    for (int k = 0; k < WPT; k++) begin
      if (p1Valid[k]) p1Count++;
    end
    for (int k = 0; k < WPT; k++) begin
      if (p1Valid[k]) begin
        slotGrant[k] = p1Grant[k];
      end else begin
        for (int j = 0; j < WPT; j++) begin
          if (p2Valid[j] && (j + p1Count == k)) slotGrant[k] = p2Grant[j];
        end
      end
    end
    for (int j = 0; j < WPT; j++) begin
      if (p2Valid[j] && (j + p1Count < WPT)) begin
        for (int i = 0; i < NFU; i++) begin
          if (p2Grant[j][i]) ptr_d = PW'((i + 1) % NFU);
        end
      end
    end
  end

  always_comb begin
    grantMask = '0;
    for (int k = 0; k < WPT; k++) grantMask |= slotGrant[k];
  end

  assign bus.claim = rst ? '0 : grantMask;

  // Starvation counters saturate at 15 so ungranted starved units stay starved.
  always_comb begin
    starveCnt_d = '0;
    for (int i = 0; i < NFU; i++) begin
      if (elig[i] && !grantMask[i]) begin
        starveCnt_d[i] = (starveCnt_q[i] == 4'hF) ? 4'hF : starveCnt_q[i] + 4'd1;
      end
    end
  end

  // Writeback mux; the redirect filter on load is a safety net for bundles
  // that became younger than the current redirect.
  always_comb begin
    wb_d = '0;
    for (int k = 0; k < WPT; k++) begin
      for (int i = 0; i < NFU; i++) begin
        if (slotGrant[k][i]) wb_d[k] = bus.cand[i];
      end
      if (isYounger(wb_d[k].opid, bus.redir, IDW)) wb_d[k].opid = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt_q <= '0;
      ptr_q       <= '0;
      wb_q        <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      ptr_q       <= ptr_d;
      wb_q        <= wb_d;
    end
  end

  assign bus.wb = wb_q;

endmodule
